// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts unsigned or two's-complement input under a start/done handshake and
// produces packed BCD digits plus sign, overflow and leading-zero blanking flags.
module bcd_seq_conv #(
  parameter int BIN_WIDTH = 13,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  // Every digit blank except the units digit, so a cleared display still shows "0".
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                 state;
  logic [BIN_WIDTH-1:0]   shreg;
  logic [4*DIGITS-1:0]    digits;
  logic                   ovf_acc;
  logic                   neg_pend;
  logic [CW-1:0]          count;

  logic [BIN_WIDTH-1:0]   mag;
  logic                   is_neg;
  logic [4*DIGITS-1:0]    adj;
  logic [DIGITS-1:0]      blank_next;

  // Magnitude of the incoming value; the most negative input maps to 2^(W-1) as unsigned.
  always_comb begin
    is_neg = signed_mode & binary[BIN_WIDTH-1];
    mag    = is_neg ? ('0 - binary) : binary;
  end

  // Add-3 correction: any working digit of 5 or more becomes digit+3 before the shift.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digits[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = digits[4*d +: 4] + 4'd3;
      else
        adj[4*d +: 4] = digits[4*d +: 4];
    end
  end

  // Leading-zero blanking: digit d blanks when it and every higher digit are zero.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    blank_next = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      all_zero      = all_zero & (digits[4*d +: 4] == 4'd0);
      blank_next[d] = all_zero;
    end
    blank_next[0] = 1'b0;
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      digits   <= '0;
      ovf_acc  <= 1'b0;
      neg_pend <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      blank    <= BLANK_RST;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            shreg    <= mag;
            neg_pend <= is_neg;
            digits   <= '0;
            ovf_acc  <= 1'b0;
            count    <= CW'(BIN_WIDTH);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          busy    <= 1'b1;
          digits  <= {adj[4*DIGITS-2:0], shreg[BIN_WIDTH-1]};
          ovf_acc <= ovf_acc | adj[4*DIGITS-1];
          shreg   <= {shreg[BIN_WIDTH-2:0], 1'b0};
          count   <= count - 1'b1;
          if (count == CW'(1))
            state <= DONE;
        end
        DONE: begin
          busy     <= 1'b1;
          bcd      <= digits;
          negative <= neg_pend;
          overflow <= ovf_acc;
          blank    <= blank_next;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: scoreboard bench for bcd_seq_conv, one default instance
// (13-bit, 4 digits) and one 3-digit instance for the overflow cases.
module tb_bcd_seq_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [12:0] bin4 = '0;
  logic        busy4, done4, neg4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;

  logic        start3 = 1'b0, sgn3 = 1'b0;
  logic [12:0] bin3 = '0;
  logic        busy3, done3, neg3, ovf3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    logic        ovf;
    logic [3:0]  blank;
    int          done_cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  bcd_seq_conv #(.BIN_WIDTH(13), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sgn4), .binary(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .negative(neg4), .overflow(ovf4), .blank(blank4)
  );

  bcd_seq_conv #(.BIN_WIDTH(13), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sgn3), .binary(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .negative(neg3), .overflow(ovf3), .blank(blank3)
  );

  // Free-running clock and edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference model: decimal arithmetic on the magnitude, independent of the shift algorithm.
  function automatic exp_t model(input logic [12:0] b, input logic s, input int nd, input int dcyc);
    exp_t e;
    int   mag, lim, v;
    e.neg   = s && b[12];
    mag     = e.neg ? (8192 - int'(b)) : int'(b);
    lim     = 10 ** nd;
    e.ovf   = (mag >= lim);
    v       = mag % lim;
    e.bcd   = '0;
    e.blank = '0;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    for (int d = 1; d < nd; d++)
      e.blank[d] = ((e.bcd >> (4*d)) == 16'd0);
    e.done_cyc = dcyc;
    return e;
  endfunction

  // Drive one start pulse; the expected result is queued unless the conversion is meant to be aborted.
  task automatic applyStimulus(input bit sel3, input logic [12:0] b, input bit s, input bit push);
    int n;
    @(negedge clk);
    n = cyc + 1;
    if (sel3) begin
      start3 = 1'b1; bin3 = b; sgn3 = s;
      if (push) q3.push_back(model(b, s, 3, n + 14));
    end else begin
      start4 = 1'b1; bin4 = b; sgn4 = s;
      if (push) q4.push_back(model(b, s, 4, n + 14));
    end
    @(negedge clk);
    start3 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((q4.size() != 0 || q3.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) checkOutput("timeout_waiting_done", 32'(q4.size() + q3.size()), 32'd0);
  endtask

  // Scoreboard for the 4-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checkOutput("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        checkOutput("bcd4", 32'(bcd4), 32'(e.bcd));
        checkOutput("neg4", 32'(neg4), 32'(e.neg));
        checkOutput("ovf4", 32'(ovf4), 32'(e.ovf));
        checkOutput("blank4", 32'(blank4), 32'(e.blank));
        checkOutput("latency4", 32'(cyc), 32'(e.done_cyc));
        checkOutput("busy_at_done4", 32'(busy4), 32'd1);
      end
    end
  end

  // Scoreboard for the 3-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        checkOutput("unexpected_done3", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        checkOutput("bcd3", 32'(bcd3), 32'(e.bcd));
        checkOutput("neg3", 32'(neg3), 32'(e.neg));
        checkOutput("ovf3", 32'(ovf3), 32'(e.ovf));
        checkOutput("blank3", {28'd0, 1'b0, blank3}, 32'(e.blank));
        checkOutput("latency3", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy4), 32'd0);
    checkOutput({tag, "_done"}, 32'(done4), 32'd0);
    checkOutput({tag, "_bcd"}, 32'(bcd4), 32'd0);
    checkOutput({tag, "_neg"}, 32'(neg4), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(ovf4), 32'd0);
    checkOutput({tag, "_blank"}, 32'(blank4), 32'hE);
    checkOutput({tag, "_blank3"}, 32'(blank3), 32'h6);
  endtask

  initial begin
    int n;
    logic [12:0] r;
    $display("[TB] starting bcd_seq_conv bench");
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values on the default instance.
    applyStimulus(0, 13'd8191, 0, 1); waitIdle();
    @(negedge clk);
    checkOutput("busy_idle", 32'(busy4), 32'd0);
    applyStimulus(0, 13'd0,    0, 1); waitIdle();
    applyStimulus(0, 13'h1FFF, 1, 1); waitIdle();
    applyStimulus(0, 13'h1000, 1, 1); waitIdle();
    applyStimulus(0, 13'h1000, 0, 1); waitIdle();
    applyStimulus(0, 13'd0,    1, 1); waitIdle();
    applyStimulus(0, 13'd9,    0, 1); waitIdle();
    applyStimulus(0, 13'h1F9C, 1, 1); waitIdle();

    // Overflow cases on the 3-digit instance.
    applyStimulus(1, 13'd1234, 0, 1); waitIdle();
    applyStimulus(1, 13'd999,  0, 1); waitIdle();
    applyStimulus(1, 13'd1000, 0, 1); waitIdle();
    applyStimulus(1, 13'h1000, 1, 1); waitIdle();

    // Random values on both instances.
    for (int i = 0; i < 6; i++) begin
      r = 13'($urandom);
      applyStimulus(i[0], r, 1'($urandom), 1);
      waitIdle();
    end

    // Start pulse during SHIFT with different data must be ignored.
    applyStimulus(0, 13'd1234, 0, 1);
    repeat (4) @(negedge clk);
    checkOutput("busy_mid", 32'(busy4), 32'd1);
    start4 = 1'b1; bin4 = 13'd777; sgn4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    waitIdle();
    repeat (20) @(negedge clk);

    // Start held high: conversions complete every 15 cycles.
    @(negedge clk);
    n = cyc + 1;
    start4 = 1'b1; bin4 = 13'd4095; sgn4 = 1'b0;
    q4.push_back(model(13'd4095, 0, 4, n + 14));
    q4.push_back(model(13'd4095, 0, 4, n + 29));
    q4.push_back(model(13'd4095, 0, 4, n + 44));
    while (cyc < n + 30) @(negedge clk);
    start4 = 1'b0;
    waitIdle();
    @(negedge clk);
    checkOutput("busy_after_burst", 32'(busy4), 32'd0);

    // Reset in the middle of a conversion aborts it.
    applyStimulus(0, 13'd4321, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done_bcd", 32'(bcd4), 32'd0);
    applyStimulus(0, 13'd5678, 0, 1); waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("queue4_empty", 32'(q4.size()), 32'd0);
    checkOutput("queue3_empty", 32'(q3.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
